// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [3:0] BE_WORD = 4'hF;

  localparam int DEF_TIMEOUT    = 16;
  localparam int DEF_MAX_STREAK = 4;

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter for one memory access; expire flags the last allowed cycle.
module bus_timeout_counter #(
  parameter int TIMEOUT = arb_pkg::DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between the fetch and data ports,
// with data priority, a fetch anti-starvation streak limit and an access timeout.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_be,
  input  logic              m_ack,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  arb_state_e    state, state_d;
  owner_e        owner;
  logic [SW-1:0] streak;
  logic          drop;
  logic          grant_d, grant_f, fin_ok, fin_err;
  logic          in_access, expire;

  assign in_access = (state == FETCH) || (state == DATA);

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_access),
    .enable (in_access),
    .expire (expire)
  );

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state;
    grant_d = 1'b0;
    grant_f = 1'b0;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && !(if_req && (streak == STREAK_MAX) && !if_flush)) begin
          grant_d = 1'b1;
          state_d = DATA;
        end else if (if_req && !if_flush) begin
          grant_f = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH, DATA: begin
        // An ack on the final timer cycle still counts as success.
        if (m_ack) begin
          fin_ok  = 1'b1;
          state_d = RESP;
        end else if (expire) begin
          fin_err = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      streak   <= '0;
      drop     <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      if_ready <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= '0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      busy     <= (state_d != IDLE);
      if_ready <= 1'b0;
      if_err   <= 1'b0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;

      if (grant_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_be    <= d_be;
        owner   <= OWN_D;
        if (!if_req)                  streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end else if (grant_f) begin
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        m_be    <= BE_WORD;
        owner   <= OWN_IF;
        streak  <= '0;
      end

      if (fin_ok || fin_err) begin
        m_req <= 1'b0;
        if (owner == OWN_D) begin
          d_ready <= fin_ok;
          d_err   <= fin_err;
          d_rdata <= fin_ok ? m_rdata : 32'h0;
        end else if (!(drop || if_flush)) begin
          // A flushed fetch finishes on the bus but is invisible to the pipeline.
          if_ready <= fin_ok;
          if_err   <= fin_err;
          if_rdata <= fin_ok ? m_rdata : 32'h0;
        end
      end

      if (state_d == IDLE)                                 drop <= 1'b0;
      else if (if_flush && (state == FETCH || state == RESP)) drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: single-access vector table, corner-case sequences and a
// randomized run against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT    = 16;
  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ready, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks after cur_wait idle cycles; 1000 means never.
  logic [31:0] mem [logic [31:0]];
  int cur_wait = 0, fixed_wait = 0, wcnt = 0;
  bit rand_wait = 1'b0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!m_req) begin
      m_ack = 1'b0;
      wcnt  = 0;
      if (rand_wait) cur_wait = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 3));
      else           cur_wait = fixed_wait;
    end else begin
      if (wcnt == cur_wait) begin
        logic [31:0] w;
        m_ack   = 1'b1;
        m_rdata = mem_read(m_addr);
        if (m_we) begin
          w = mem_read(m_addr);
          for (int b = 0; b < 4; b++) if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
          mem[m_addr] = w;
        end
      end else begin
        m_ack   = 1'b0;
        m_rdata = 32'hDEAD0000 | 32'(wcnt);
      end
      wcnt++;
    end
  end

  typedef struct {
    string       name;
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_c;
    int          exp_ready;
    int          exp_err;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_mreq;
  } vec_t;

  vec_t vecs[7];

  task automatic run_single(input vec_t v);
    int nreq = 0, got_r = 0, got_e = 0;
    bit fin = 1'b0, first = 1'b1;
    logic [31:0] rd = '0, a0 = '0;
    logic [3:0]  be0 = '0;
    logic        we0 = 1'b0;
    fixed_wait = v.wait_c;
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int c = 0; c < 60 && !fin; c++) begin
      tick();
      if (m_req) begin
        nreq++;
        if (first) begin a0 = m_addr; be0 = m_be; we0 = m_we; first = 1'b0; end
      end
      if (v.is_data ? d_ready : if_ready) begin got_r++; rd = v.is_data ? d_rdata : if_rdata; end
      if (v.is_data ? d_err : if_err)     begin got_e++; rd = v.is_data ? d_rdata : if_rdata; end
      if (got_r + got_e > 0) begin d_req = 1'b0; if_req = 1'b0; fin = 1'b1; end
    end
    d_req = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (m_req) nreq++;
      if (if_ready || d_ready) got_r++;
      if (if_err || d_err) got_e++;
    end
    check({v.name, "_mreq_cycles"}, 32'(nreq), 32'(v.exp_mreq));
    check({v.name, "_addr"}, a0, v.addr);
    check({v.name, "_be"}, 32'(be0), v.is_data ? 32'(v.be) : 32'hF);
    check({v.name, "_we"}, 32'(we0), 32'(v.is_data && v.we));
    check({v.name, "_ready"}, 32'(got_r), 32'(v.exp_ready));
    check({v.name, "_err"}, 32'(got_e), 32'(v.exp_err));
    if (v.chk_rdata) check({v.name, "_rdata"}, rd, v.exp_rdata);
    check({v.name, "_busy_after"}, 32'(busy), 32'h0);
  endtask

  // Randomized-run state
  logic        p_if_req, p_d_req, p_d_we;
  logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
  logic [3:0]  p_d_be;
  bit          m_req_q, pend_v, pend_d, pend_ok, pend_we, exp_d;
  logic [31:0] pend_data;
  int          mstreak, if_age, d_age;
  logic [3:0]  pulses, exp_p;
  logic [31:0] ga [8];
  int          gc [8];
  int          ng;

  initial begin
    mem[32'h100] = 32'h24080005;
    //         name          data we  addr          wdata         be    wait  rdy err chk rdata         mreq
    vecs[0] = '{"fetch_w2",  0,   0,  32'h100,  32'h0,        4'h0, 2,    1,  0,  1,  32'h24080005, 3};
    vecs[1] = '{"store_w0",  1,   1,  32'h2000, 32'h0000BEEF, 4'h3, 0,    1,  0,  0,  32'h0,        1};
    vecs[2] = '{"load_w1",   1,   0,  32'h2000, 32'h0,        4'hF, 1,    1,  0,  1,  32'h7a5abeef, 2};
    vecs[3] = '{"load_tmo",  1,   0,  32'h3000, 32'h0,        4'hF, 1000, 0,  1,  1,  32'h0,        16};
    vecs[4] = '{"fetch_w15", 0,   0,  32'h44,   32'h0,        4'h0, 15,   1,  0,  1,  32'h5a1e0044, 16};
    vecs[5] = '{"fetch_tmo", 0,   0,  32'h80,   32'h0,        4'h0, 1000, 0,  1,  1,  32'h0,        16};
    vecs[6] = '{"load_w15",  1,   0,  32'h3000, 32'h0,        4'hF, 15,   1,  0,  1,  32'h6a5a3000, 16};

    // Reset state
    #12;
    check("rst_m_req", 32'(m_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", 32'({if_ready, if_err, d_ready, d_err}), 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_single(vecs[i]);

    // Simultaneous requests: data first, fetch in the IDLE cycle after data RESP.
    fixed_wait = 0; ng = 0; m_req_q = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h0000BEEF; d_be = 4'h3;
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (m_req && !m_req_q && ng < 8) begin
        ga[ng] = m_addr; gc[ng] = c;
        if (ng == 0) begin
          check("simul_first_we", 32'(m_we), 1);
          check("simul_first_be", 32'(m_be), 32'h3);
        end
        ng++;
      end
      m_req_q = m_req;
      if (d_ready) d_req = 1'b0;
      if (if_ready) if_req = 1'b0;
    end
    check("simul_grants", 32'(ng), 2);
    check("simul_first_addr", ga[0], 32'h2000);
    check("simul_second_addr", ga[1], 32'h100);
    check("simul_gap", 32'(gc[1] - gc[0]), 3);

    // Starvation: data held permanently, fetch wins the 5th grant.
    ng = 0; m_req_q = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      tick();
      if (m_req && !m_req_q) begin ga[ng] = m_addr; ng++; end
      m_req_q = m_req;
    end
    check("starve_grants", 32'(ng), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("starve_grant%0d", i), ga[i], (i == 4) ? 32'h100 : 32'h2000);
    d_req = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 6; c++) tick();

    // Flush during wait cycle 1, ack in wait cycle 3.
    begin
      int nreq = 0, npulse = 0;
      fixed_wait = 3;
      if_req = 1'b1; if_addr = 32'h200;
      for (int c = 0; c < 10 && !m_req; c++) tick();
      if (m_req) nreq++;
      tick();
      if (m_req) nreq++;
      if_flush = 1'b1; if_req = 1'b0;
      tick();
      if_flush = 1'b0;
      for (int c = 0; c < 12; c++) begin
        if (m_req) nreq++;
        if (if_ready || if_err) npulse++;
        tick();
      end
      check("flush_mreq_cycles", 32'(nreq), 4);
      check("flush_pulses", 32'(npulse), 0);
      check("flush_busy_after", 32'(busy), 0);
    end

    // Asynchronous reset mid-DATA.
    fixed_wait = 1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_be = 4'hF;
    for (int c = 0; c < 4; c++) tick();
    check("areset_pre_mreq", 32'(m_req), 1);
    #3 rst_n = 1'b0;
    #1;
    check("areset_mreq", 32'(m_req), 0);
    check("areset_busy", 32'(busy), 0);
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_single(vecs[0]);

    // Randomized traffic against a transaction-level model.
    rand_wait = 1'b1;
    m_req_q = 1'b0; pend_v = 1'b0; mstreak = 0; if_age = 0; d_age = 0;
    p_if_req = 1'b0; p_d_req = 1'b0;
    p_if_addr = '0; p_d_addr = '0; p_d_we = 1'b0; p_d_wdata = '0; p_d_be = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (m_req && !m_req_q) begin
        exp_d = p_d_req && !(p_if_req && mstreak == MAX_STREAK);
        check("rand_grant_addr", m_addr, exp_d ? p_d_addr : p_if_addr);
        check("rand_grant_we", 32'(m_we), 32'(exp_d && p_d_we));
        check("rand_grant_be", 32'(m_be), exp_d ? 32'(p_d_be) : 32'hF);
        if (exp_d && p_d_we) check("rand_grant_wdata", m_wdata, p_d_wdata);
        if (exp_d && p_if_req) mstreak = (mstreak < MAX_STREAK) ? mstreak + 1 : MAX_STREAK;
        else                   mstreak = 0;
        pend_v    = 1'b1;
        pend_d    = exp_d;
        pend_ok   = (cur_wait < TIMEOUT);
        pend_we   = exp_d && p_d_we;
        pend_data = mem_read(exp_d ? p_d_addr : p_if_addr);
      end
      m_req_q = m_req;
      check("rand_busy", 32'(busy), 32'(pend_v));
      pulses = {if_ready, if_err, d_ready, d_err};
      if (pulses != 4'b0 || pend_v) begin
        if (pulses != 4'b0) begin
          exp_p = !pend_v ? 4'b0000 :
                  pend_d  ? (pend_ok ? 4'b0010 : 4'b0001) :
                            (pend_ok ? 4'b1000 : 4'b0100);
          check("rand_pulse", 32'(pulses), 32'(exp_p));
          if (pend_v && !pend_we)
            check("rand_rdata", pend_d ? d_rdata : if_rdata, pend_ok ? pend_data : 32'h0);
          pend_v = 1'b0;
          if (if_ready || if_err) if_req = 1'b0;
          if (d_ready || d_err)   d_req  = 1'b0;
        end
      end
      if_age = if_req ? if_age + 1 : 0;
      d_age  = d_req  ? d_age + 1  : 0;
      if (if_age > 150 || d_age > 150) begin
        nvec++; nerr++;
        $display("FAIL rand_stall: request pending %0d/%0d cycles, expected under 150", if_age, d_age);
        if_req = 1'b0; d_req = 1'b0; if_age = 0; d_age = 0;
      end
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'h1000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        d_wdata = $urandom; d_be = 4'($urandom_range(1, 15));
      end
      p_if_req = if_req; p_if_addr = if_addr;
      p_d_req = d_req; p_d_we = d_we; p_d_addr = d_addr; p_d_wdata = d_wdata; p_d_be = d_be;
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    check("final_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
